// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//   Central sequencer of the CNN accelerator. A one-cycle `start` in IDLE runs
//   conv1, conv2 and fc back to back. Each tile goes through weight load (LW),
//   ifmap load (LI), compute (CP) and write-back (WB). `done` pulses for one
//   cycle when the last fc tile has been written back.
//
// Ports
//   clk, rst (async, active low), start (sampled in IDLE only)
//   done, cnt                        : completion pulse, in-state cycle counter
//   bram_*_ren / *_addr / *_raddr    : BRAM read strobes and addresses
//   bram_ofmap{1,2}_wen / _waddr     : ofmap BRAM write port
//   i_buff_*, w_buff_*               : ifmap / weight buffer write + clear
//   p_buff_wen, p_buff_r_addr        : psum buffer write strobe, read address
//   align_conv1/2, fc_reg_*, *_pe_wen, MPSF_clear : datapath / PE control
//   mux_*_sel                        : datapath mux selects
//
// Every output is a register. Read-side outputs are decoded from the next
// state/count; write strobes are the current read strobes delayed one cycle,
// which matches the one-cycle BRAM/buffer read latency.
// -----------------------------------------------------------------------------
module controller #(
  parameter int CNT_W    = 10,
  parameter int IMG_AW   = 10,
  parameter int WGT_AW   = 13,
  parameter int BIAS_AW  = 7,
  parameter int OF1_AW   = 11,
  parameter int OF2_AW   = 9,
  parameter int IB_AW    = 5,
  parameter int WB_AW    = 5,
  parameter int PB_AW    = 5,
  parameter int L1_TILES = 6,
  parameter int L2_TILES = 16,
  parameter int FC_TILES = 10,
  parameter int LOAD_LEN = 25,
  parameter int COMP_LEN = 24,
  parameter int WB_LEN   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  output logic [CNT_W-1:0]   cnt,
  output logic               bram_img_ren,
  output logic [IMG_AW-1:0]  bram_img_addr,
  output logic               bram_weight_ren,
  output logic [WGT_AW-1:0]  bram_weight_addr,
  output logic               bram_bias_ren,
  output logic [BIAS_AW-1:0] bram_bias_addr,
  output logic               bram_ofmap1_ren,
  output logic [OF1_AW-1:0]  bram_ofmap1_raddr,
  output logic               bram_ofmap2_ren,
  output logic [OF2_AW-1:0]  bram_ofmap2_raddr,
  output logic               bram_ofmap1_wen,
  output logic [OF1_AW-1:0]  bram_ofmap1_waddr,
  output logic               bram_ofmap2_wen,
  output logic [OF2_AW-1:0]  bram_ofmap2_waddr,
  output logic               i_buff_wen,
  output logic [IB_AW-1:0]   i_buff_w_addr,
  output logic               i_buff_clear,
  output logic               w_buff_wen,
  output logic [WB_AW-1:0]   w_buff_w_addr,
  output logic               w_buff_clear,
  output logic               p_buff_wen,
  output logic [PB_AW-1:0]   p_buff_r_addr,
  output logic               align_conv1,
  output logic               align_conv2,
  output logic               fc_reg_wen,
  output logic               fc_reg_clear,
  output logic               ifmap_pe_wen,
  output logic               weight_pe_wen,
  output logic               MPSF_clear,
  output logic [1:0]         mux_if_sel,
  output logic [1:0]         mux_pb_sel,
  output logic [1:0]         mux_of_sel,
  output logic               mux_of12_in_sel,
  output logic               mux_of12_out_sel
);

  typedef enum logic [4:0] {
    IDLE  = 5'd0,
    C1_LW = 5'd1,  C1_LI = 5'd2,  C1_CP = 5'd3,  C1_WB = 5'd4,
    C2_LW = 5'd5,  C2_LI = 5'd6,  C2_CP = 5'd7,  C2_WB = 5'd8,
    FC_LW = 5'd9,  FC_LI = 5'd10, FC_CP = 5'd11, FC_WB = 5'd12,
    DONE  = 5'd13
  } state_t;

  typedef enum logic [2:0] {PH_NONE, PH_LW, PH_LI, PH_CP, PH_WB} phase_t;

  // Read-side controls decoded for the coming cycle.
  typedef struct packed {
    logic       done;
    logic       w_ren;
    logic       w_clr;
    logic       b_ren;
    logic       img_ren;
    logic       of1_ren;
    logic       of2_ren;
    logic       i_clr;
    logic       pb_rd;
    logic       if_pe;
    logic       w_pe;
    logic       mpsf;
    logic       p_wen;
    logic       al1;
    logic       al2;
    logic       fc_wen;
    logic       fc_clr;
    logic       of12_in;
    logic       of12_out;
    logic [1:0] if_sel;
    logic [1:0] of_sel;
    logic [1:0] pb_sel;
  } ctl_t;

  // Layer index: 0 = conv1, 1 = conv2, 2 = fc (0 for IDLE/DONE too).
  function automatic logic [1:0] layer_of(state_t s);
    case (s)
      C2_LW, C2_LI, C2_CP, C2_WB: return 2'd1;
      FC_LW, FC_LI, FC_CP, FC_WB: return 2'd2;
      default:                    return 2'd0;
    endcase
  endfunction

  function automatic phase_t phase_of(state_t s);
    case (s)
      C1_LW, C2_LW, FC_LW: return PH_LW;
      C1_LI, C2_LI, FC_LI: return PH_LI;
      C1_CP, C2_CP, FC_CP: return PH_CP;
      C1_WB, C2_WB, FC_WB: return PH_WB;
      default:             return PH_NONE;
    endcase
  endfunction

  function automatic int tiles_of(state_t s);
    case (layer_of(s))
      2'd1:    return L2_TILES;
      2'd2:    return FC_TILES;
      default: return L1_TILES;
    endcase
  endfunction

  state_t             st, nxt_st;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [7:0]         tile, nxt_tile;       // tile index within the layer
  logic [BIAS_AW-1:0] gtile, nxt_gtile;     // tile index across the whole run
  logic               run_start;
  logic [WGT_AW-1:0]  wgt_ptr, wgt_base;
  logic [OF1_AW-1:0]  c1_ptr, fc_ptr;
  logic [OF2_AW-1:0]  c2_ptr;
  logic               pb_vld;               // psum read issued this cycle
  logic               li_rd;
  logic [1:0]         nxt_layer;
  ctl_t               d;

  // ---------------------------------------------------------------------------
  // Next state / counter
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    nxt_st    = st;
    nxt_cnt   = cnt + 1'b1;
    nxt_tile  = tile;
    nxt_gtile = gtile;
    run_start = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) begin
          nxt_st    = C1_LW;
          nxt_cnt   = '0;
          nxt_tile  = '0;
          nxt_gtile = '0;
          run_start = 1'b1;
        end
      end
      C1_LW, C2_LW, FC_LW, C1_LI, C2_LI, FC_LI: begin
        if (cnt == CNT_W'(LOAD_LEN)) begin
          nxt_st  = state_t'(st + 5'd1);
          nxt_cnt = '0;
        end
      end
      C1_CP, C2_CP, FC_CP: begin
        if (cnt == CNT_W'(COMP_LEN - 1)) begin
          nxt_st  = state_t'(st + 5'd1);
          nxt_cnt = '0;
        end
      end
      C1_WB, C2_WB, FC_WB: begin
        if (cnt == CNT_W'(WB_LEN)) begin
          nxt_cnt   = '0;
          nxt_gtile = gtile + 1'b1;
          if (tile == 8'(tiles_of(st) - 1)) begin
            // Last tile of the layer: move on to the next layer (or finish).
            nxt_tile = '0;
            nxt_st   = (st == FC_WB) ? DONE : state_t'(st + 5'd1);
          end else begin
            nxt_tile = tile + 8'd1;
            nxt_st   = state_t'(st - 5'd3);
          end
        end
      end
      DONE: begin
        nxt_st  = IDLE;
        nxt_cnt = '0;
      end
      default: begin
        nxt_st  = IDLE;
        nxt_cnt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-side decode for the coming cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    d         = '0;
    nxt_layer = layer_of(nxt_st);
    d.done     = (nxt_st == DONE);
    d.of12_out = (nxt_layer == 2'd2);
    unique case (phase_of(nxt_st))
      PH_LW: begin
        d.w_ren  = (nxt_cnt < CNT_W'(LOAD_LEN));
        d.w_clr  = (nxt_cnt == '0);
        d.b_ren  = (nxt_cnt == '0);
        d.fc_clr = (nxt_layer == 2'd2) && (nxt_cnt == '0);
      end
      PH_LI: begin
        d.img_ren = (nxt_layer == 2'd0) && (nxt_cnt < CNT_W'(LOAD_LEN));
        d.of1_ren = (nxt_layer == 2'd1) && (nxt_cnt < CNT_W'(LOAD_LEN));
        d.of2_ren = (nxt_layer == 2'd2) && (nxt_cnt < CNT_W'(LOAD_LEN));
        d.if_sel  = nxt_layer;
        d.i_clr   = (nxt_cnt == '0);
      end
      PH_CP: begin
        d.if_pe  = (nxt_cnt == '0);
        d.w_pe   = (nxt_cnt == '0);
        d.mpsf   = (nxt_cnt == '0);
        d.p_wen  = (nxt_layer != 2'd2) && (nxt_cnt != '0);
        d.al1    = (nxt_layer == 2'd0);
        d.al2    = (nxt_layer == 2'd1);
        d.fc_wen = (nxt_layer == 2'd2);
      end
      PH_WB: begin
        // fc produces a single result word per tile.
        d.pb_rd   = (nxt_layer == 2'd2) ? (nxt_cnt == '0)
                                        : (nxt_cnt < CNT_W'(WB_LEN));
        d.of_sel  = nxt_layer;
        d.pb_sel  = nxt_layer;
        d.of12_in = (nxt_layer == 2'd2);
      end
      default: ;
    endcase
  end

  // Pointers restart from zero for every new run.
  assign wgt_base = run_start ? '0 : wgt_ptr;
  assign li_rd    = bram_img_ren | bram_ofmap1_ren | bram_ofmap2_ren;

  // ---------------------------------------------------------------------------
  // State, pointers and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others (the write strobes rely on this to trail
  // the read strobes by exactly one cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st                <= IDLE;
      cnt               <= '0;
      tile              <= '0;
      gtile             <= '0;
      wgt_ptr           <= '0;
      c1_ptr            <= '0;
      c2_ptr            <= '0;
      fc_ptr            <= '0;
      pb_vld            <= 1'b0;
      done              <= 1'b0;
      bram_img_ren      <= 1'b0;
      bram_img_addr     <= '0;
      bram_weight_ren   <= 1'b0;
      bram_weight_addr  <= '0;
      bram_bias_ren     <= 1'b0;
      bram_bias_addr    <= '0;
      bram_ofmap1_ren   <= 1'b0;
      bram_ofmap1_raddr <= '0;
      bram_ofmap2_ren   <= 1'b0;
      bram_ofmap2_raddr <= '0;
      bram_ofmap1_wen   <= 1'b0;
      bram_ofmap1_waddr <= '0;
      bram_ofmap2_wen   <= 1'b0;
      bram_ofmap2_waddr <= '0;
      i_buff_wen        <= 1'b0;
      i_buff_w_addr     <= '0;
      i_buff_clear      <= 1'b0;
      w_buff_wen        <= 1'b0;
      w_buff_w_addr     <= '0;
      w_buff_clear      <= 1'b0;
      p_buff_wen        <= 1'b0;
      p_buff_r_addr     <= '0;
      align_conv1       <= 1'b0;
      align_conv2       <= 1'b0;
      fc_reg_wen        <= 1'b0;
      fc_reg_clear      <= 1'b0;
      ifmap_pe_wen      <= 1'b0;
      weight_pe_wen     <= 1'b0;
      MPSF_clear        <= 1'b0;
      mux_if_sel        <= '0;
      mux_pb_sel        <= '0;
      mux_of_sel        <= '0;
      mux_of12_in_sel   <= 1'b0;
      mux_of12_out_sel  <= 1'b0;
    end else begin
      st    <= nxt_st;
      cnt   <= nxt_cnt;
      tile  <= nxt_tile;
      gtile <= nxt_gtile;

      // Read side, aligned with the new state/count.
      done             <= d.done;
      bram_weight_ren  <= d.w_ren;
      bram_weight_addr <= d.w_ren ? wgt_base : '0;
      if (d.w_ren) wgt_ptr <= wgt_base + 1'b1;
      bram_bias_ren     <= d.b_ren;
      bram_bias_addr    <= d.b_ren ? nxt_gtile : '0;
      w_buff_clear      <= d.w_clr;
      bram_img_ren      <= d.img_ren;
      bram_img_addr     <= d.img_ren ? IMG_AW'(nxt_cnt) : '0;
      bram_ofmap1_ren   <= d.of1_ren;
      bram_ofmap1_raddr <= d.of1_ren ? OF1_AW'(nxt_cnt) : '0;
      bram_ofmap2_ren   <= d.of2_ren;
      bram_ofmap2_raddr <= d.of2_ren ? OF2_AW'(nxt_cnt) : '0;
      i_buff_clear      <= d.i_clr;
      mux_if_sel        <= d.if_sel;
      ifmap_pe_wen      <= d.if_pe;
      weight_pe_wen     <= d.w_pe;
      MPSF_clear        <= d.mpsf;
      p_buff_wen        <= d.p_wen;
      align_conv1       <= d.al1;
      align_conv2       <= d.al2;
      fc_reg_wen        <= d.fc_wen;
      fc_reg_clear      <= d.fc_clr;
      pb_vld            <= d.pb_rd;
      p_buff_r_addr     <= d.pb_rd ? PB_AW'(nxt_cnt) : '0;
      mux_of_sel        <= d.of_sel;
      mux_pb_sel        <= d.pb_sel;
      mux_of12_in_sel   <= d.of12_in;
      mux_of12_out_sel  <= d.of12_out;

      // Write side: last cycle's reads, with the count they were issued at.
      w_buff_wen    <= bram_weight_ren;
      w_buff_w_addr <= bram_weight_ren ? WB_AW'(cnt) : '0;
      i_buff_wen    <= li_rd;
      i_buff_w_addr <= li_rd ? IB_AW'(cnt) : '0;

      bram_ofmap1_wen   <= 1'b0;
      bram_ofmap1_waddr <= '0;
      bram_ofmap2_wen   <= 1'b0;
      bram_ofmap2_waddr <= '0;
      if (run_start) begin
        c1_ptr <= '0;
        c2_ptr <= '0;
        fc_ptr <= '0;
      end
      if (pb_vld) begin
        case (st)
          C1_WB: begin
            bram_ofmap1_wen   <= 1'b1;
            bram_ofmap1_waddr <= c1_ptr;
            c1_ptr            <= c1_ptr + 1'b1;
          end
          C2_WB: begin
            bram_ofmap2_wen   <= 1'b1;
            bram_ofmap2_waddr <= c2_ptr;
            c2_ptr            <= c2_ptr + 1'b1;
          end
          FC_WB: begin
            bram_ofmap1_wen   <= 1'b1;
            bram_ofmap1_waddr <= fc_ptr;
            fc_ptr            <= fc_ptr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//   Self-checking bench for controller. A reference model derives every output
//   for cycle t of a run directly from the layer/tile/phase schedule with plain
//   arithmetic; a table of probe points pins down specific corner values.
//   Runs: reset state, run aborted by reset inside C2_CP, a quiet run with
//   probes, a run with start held high and pulsed in DONE, and random-start
//   noise runs with random idle gaps.
// -----------------------------------------------------------------------------
module tb_controller;

  localparam int L1_TILES = 6;
  localparam int L2_TILES = 16;
  localparam int FC_TILES = 10;
  localparam int LOAD_LEN = 25;
  localparam int COMP_LEN = 24;
  localparam int WB_LEN   = 16;
  localparam int TILE_CYC = 2 * (LOAD_LEN + 1) + COMP_LEN + WB_LEN + 1;
  localparam int TOTAL    = (L1_TILES + L2_TILES + FC_TILES) * TILE_CYC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [9:0]  cnt;
  logic        bram_img_ren, bram_weight_ren, bram_bias_ren;
  logic [9:0]  bram_img_addr;
  logic [12:0] bram_weight_addr;
  logic [6:0]  bram_bias_addr;
  logic        bram_ofmap1_ren, bram_ofmap2_ren, bram_ofmap1_wen, bram_ofmap2_wen;
  logic [10:0] bram_ofmap1_raddr, bram_ofmap1_waddr;
  logic [8:0]  bram_ofmap2_raddr, bram_ofmap2_waddr;
  logic        i_buff_wen, i_buff_clear, w_buff_wen, w_buff_clear, p_buff_wen;
  logic [4:0]  i_buff_w_addr, w_buff_w_addr, p_buff_r_addr;
  logic        align_conv1, align_conv2, fc_reg_wen, fc_reg_clear;
  logic        ifmap_pe_wen, weight_pe_wen, MPSF_clear;
  logic [1:0]  mux_if_sel, mux_pb_sel, mux_of_sel;
  logic        mux_of12_in_sel, mux_of12_out_sel;

  controller dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .cnt(cnt),
    .bram_img_ren(bram_img_ren), .bram_img_addr(bram_img_addr),
    .bram_weight_ren(bram_weight_ren), .bram_weight_addr(bram_weight_addr),
    .bram_bias_ren(bram_bias_ren), .bram_bias_addr(bram_bias_addr),
    .bram_ofmap1_ren(bram_ofmap1_ren), .bram_ofmap1_raddr(bram_ofmap1_raddr),
    .bram_ofmap2_ren(bram_ofmap2_ren), .bram_ofmap2_raddr(bram_ofmap2_raddr),
    .bram_ofmap1_wen(bram_ofmap1_wen), .bram_ofmap1_waddr(bram_ofmap1_waddr),
    .bram_ofmap2_wen(bram_ofmap2_wen), .bram_ofmap2_waddr(bram_ofmap2_waddr),
    .i_buff_wen(i_buff_wen), .i_buff_w_addr(i_buff_w_addr), .i_buff_clear(i_buff_clear),
    .w_buff_wen(w_buff_wen), .w_buff_w_addr(w_buff_w_addr), .w_buff_clear(w_buff_clear),
    .p_buff_wen(p_buff_wen), .p_buff_r_addr(p_buff_r_addr),
    .align_conv1(align_conv1), .align_conv2(align_conv2),
    .fc_reg_wen(fc_reg_wen), .fc_reg_clear(fc_reg_clear),
    .ifmap_pe_wen(ifmap_pe_wen), .weight_pe_wen(weight_pe_wen), .MPSF_clear(MPSF_clear),
    .mux_if_sel(mux_if_sel), .mux_pb_sel(mux_pb_sel), .mux_of_sel(mux_of_sel),
    .mux_of12_in_sel(mux_of12_in_sel), .mux_of12_out_sel(mux_of12_out_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  st;
    logic [9:0]  cnt;
    logic        done;
    logic        img_ren;  logic [9:0]  img_addr;
    logic        w_ren;    logic [12:0] w_addr;
    logic        b_ren;    logic [6:0]  b_addr;
    logic        of1_ren;  logic [10:0] of1_raddr;
    logic        of2_ren;  logic [8:0]  of2_raddr;
    logic        of1_wen;  logic [10:0] of1_waddr;
    logic        of2_wen;  logic [8:0]  of2_waddr;
    logic        ib_wen;   logic [4:0]  ib_addr;  logic ib_clr;
    logic        wb_wen;   logic [4:0]  wb_addr;  logic wb_clr;
    logic        pb_wen;   logic [4:0]  pb_raddr;
    logic        al1, al2, fc_wen, fc_clr, if_pe, w_pe, mpsf;
    logic [1:0]  if_sel, pb_sel, of_sel;
    logic        of12_in, of12_out;
  } outs_t;

  typedef enum {S_WADDR, S_WBWEN, S_WBADDR, S_BIAS, S_OF1REN, S_IFSEL, S_IBWEN,
                S_OF1WEN, S_OF1WADDR, S_OF2WEN, S_OF12IN, S_DONE} sig_e;

  typedef struct {
    int   st;
    int   tile;
    int   cnt;
    sig_e sig;
    int   expv;
  } probe_t;

  localparam int NPROBE = 26;
  probe_t probes [NPROBE];

  int checks = 0;
  int errors = 0;
  int hits   = 0;

  function automatic int tiles_of(int layer);
    return (layer == 0) ? L1_TILES : (layer == 1) ? L2_TILES : FC_TILES;
  endfunction

  function automatic int tile_base(int layer);
    return (layer == 0) ? 0 : (layer == 1) ? L1_TILES : L1_TILES + L2_TILES;
  endfunction

  // Cycle t of a run (t=0 is the first C1_LW cycle) -> state code, tile, cnt.
  // t >= TOTAL is IDLE after the run.
  function automatic void decompose(input int t, output int s, output int tl, output int c);
    int rem, layer, ph;
    rem = t; layer = 0; ph = 0; s = 0; tl = 0; c = 0;
    if (t >= TOTAL) return;
    if (t == TOTAL - 1) begin
      s = 13;
      return;
    end
    while (rem >= tiles_of(layer) * TILE_CYC) begin
      rem -= tiles_of(layer) * TILE_CYC;
      layer++;
    end
    tl  = rem / TILE_CYC;
    rem = rem % TILE_CYC;
    if (rem < LOAD_LEN + 1) begin
      ph = 0; c = rem;
    end else if (rem < 2 * (LOAD_LEN + 1)) begin
      ph = 1; c = rem - (LOAD_LEN + 1);
    end else if (rem < 2 * (LOAD_LEN + 1) + COMP_LEN) begin
      ph = 2; c = rem - 2 * (LOAD_LEN + 1);
    end else begin
      ph = 3; c = rem - 2 * (LOAD_LEN + 1) - COMP_LEN;
    end
    s = 1 + 4 * layer + ph;
  endfunction

  function automatic outs_t model(int t);
    outs_t e;
    int s, tl, c, layer, ph, g, n;
    e = '0;
    decompose(t, s, tl, c);
    e.st  = 5'(s);
    e.cnt = 10'(c);
    if (s == 0) return e;
    if (s == 13) begin
      e.done = 1'b1;
      return e;
    end
    layer = (s - 1) / 4;
    ph    = (s - 1) % 4;
    g     = tile_base(layer) + tl;
    e.of12_out = (layer == 2);
    case (ph)
      0: begin
        e.w_ren  = (c < LOAD_LEN);
        e.w_addr = e.w_ren ? 13'(g * LOAD_LEN + c) : '0;
        e.wb_clr = (c == 0);
        e.b_ren  = (c == 0);
        e.b_addr = (c == 0) ? 7'(g) : '0;
        e.wb_wen = (c >= 1);
        e.wb_addr = (c >= 1) ? 5'(c - 1) : '0;
        e.fc_clr = (layer == 2) && (c == 0);
      end
      1: begin
        if (c < LOAD_LEN) begin
          if (layer == 0) begin e.img_ren = 1'b1; e.img_addr  = 10'(c); end
          if (layer == 1) begin e.of1_ren = 1'b1; e.of1_raddr = 11'(c); end
          if (layer == 2) begin e.of2_ren = 1'b1; e.of2_raddr = 9'(c);  end
        end
        e.if_sel  = 2'(layer);
        e.ib_clr  = (c == 0);
        e.ib_wen  = (c >= 1);
        e.ib_addr = (c >= 1) ? 5'(c - 1) : '0;
      end
      2: begin
        e.if_pe  = (c == 0);
        e.w_pe   = (c == 0);
        e.mpsf   = (c == 0);
        e.pb_wen = (c >= 1) && (layer < 2);
        e.al1    = (layer == 0);
        e.al2    = (layer == 1);
        e.fc_wen = (layer == 2);
      end
      default: begin
        n = (layer == 2) ? 1 : WB_LEN;
        e.pb_raddr = (c < n) ? 5'(c) : '0;
        e.of_sel   = 2'(layer);
        e.pb_sel   = 2'(layer);
        e.of12_in  = (layer == 2);
        if (c >= 1 && c <= n) begin
          if (layer == 0) begin e.of1_wen = 1'b1; e.of1_waddr = 11'(tl * WB_LEN + c - 1); end
          if (layer == 1) begin e.of2_wen = 1'b1; e.of2_waddr = 9'(tl * WB_LEN + c - 1);  end
          if (layer == 2) begin e.of1_wen = 1'b1; e.of1_waddr = 11'(tl); end
        end
      end
    endcase
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = dut.st;            o.cnt = cnt;             o.done = done;
    o.img_ren = bram_img_ren;       o.img_addr = bram_img_addr;
    o.w_ren = bram_weight_ren;      o.w_addr = bram_weight_addr;
    o.b_ren = bram_bias_ren;        o.b_addr = bram_bias_addr;
    o.of1_ren = bram_ofmap1_ren;    o.of1_raddr = bram_ofmap1_raddr;
    o.of2_ren = bram_ofmap2_ren;    o.of2_raddr = bram_ofmap2_raddr;
    o.of1_wen = bram_ofmap1_wen;    o.of1_waddr = bram_ofmap1_waddr;
    o.of2_wen = bram_ofmap2_wen;    o.of2_waddr = bram_ofmap2_waddr;
    o.ib_wen = i_buff_wen; o.ib_addr = i_buff_w_addr; o.ib_clr = i_buff_clear;
    o.wb_wen = w_buff_wen; o.wb_addr = w_buff_w_addr; o.wb_clr = w_buff_clear;
    o.pb_wen = p_buff_wen; o.pb_raddr = p_buff_r_addr;
    o.al1 = align_conv1; o.al2 = align_conv2; o.fc_wen = fc_reg_wen; o.fc_clr = fc_reg_clear;
    o.if_pe = ifmap_pe_wen; o.w_pe = weight_pe_wen; o.mpsf = MPSF_clear;
    o.if_sel = mux_if_sel; o.pb_sel = mux_pb_sel; o.of_sel = mux_of_sel;
    o.of12_in = mux_of12_in_sel; o.of12_out = mux_of12_out_sel;
    return o;
  endfunction

  function automatic int get_sig(sig_e s);
    case (s)
      S_WADDR:    return int'(bram_weight_addr);
      S_WBWEN:    return int'(w_buff_wen);
      S_WBADDR:   return int'(w_buff_w_addr);
      S_BIAS:     return int'(bram_bias_addr);
      S_OF1REN:   return int'(bram_ofmap1_ren);
      S_IFSEL:    return int'(mux_if_sel);
      S_IBWEN:    return int'(i_buff_wen);
      S_OF1WEN:   return int'(bram_ofmap1_wen);
      S_OF1WADDR: return int'(bram_ofmap1_waddr);
      S_OF2WEN:   return int'(bram_ofmap2_wen);
      S_OF12IN:   return int'(mux_of12_in_sel);
      default:    return int'(done);
    endcase
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d cnt=%0d bits=%h, want st=%0d cnt=%0d bits=%h",
               name, got.st, got.cnt, got, exp.st, exp.cnt, exp);
    end
  endtask

  task automatic check_cycle(input int t, input bit probes_on);
    outs_t got, exp;
    int s, tl, c;
    exp = model(t);
    got = sample();
    if (exp.st == 5'd0) got.cnt = '0;   // cnt free-runs in IDLE; not modelled
    check($sformatf("cycle t=%0d", t), got, exp);
    if (probes_on) begin
      decompose(t, s, tl, c);
      for (int i = 0; i < NPROBE; i++) begin
        if (probes[i].st == s && probes[i].tile == tl && probes[i].cnt == c) begin
          checks++;
          hits++;
          if (get_sig(probes[i].sig) != probes[i].expv) begin
            errors++;
            $display("FAIL probe %0d %s st=%0d tile=%0d cnt=%0d: got %0d want %0d",
                     i, probes[i].sig.name(), s, tl, c, get_sig(probes[i].sig), probes[i].expv);
          end
        end
      end
    end
  endtask

  task automatic idle_gap(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle(TOTAL, 1'b0);
    end
  endtask

  // mode 0: start pulse only; 1: random start noise during the run;
  // 2: start held through the run including DONE. last = final cycle checked.
  task automatic run_checked(input int mode, input int last, input bit probes_on);
    start = 1'b1;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      check_cycle(t, probes_on);
      case (mode)
        1:       start = (t <= TOTAL - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        2:       start = (t <= TOTAL - 1);
        default: start = 1'b0;
      endcase
    end
    start = 1'b0;
  endtask

  initial begin
    probes = '{
      '{1, 0, 0,  S_WADDR,    0},
      '{1, 0, 24, S_WADDR,    24},
      '{1, 0, 0,  S_WBWEN,    0},
      '{1, 0, 1,  S_WBWEN,    1},
      '{1, 0, 1,  S_WBADDR,   0},
      '{1, 0, 25, S_WBWEN,    1},
      '{1, 0, 25, S_WBADDR,   24},
      '{1, 1, 0,  S_WADDR,    25},
      '{6, 0, 0,  S_OF1REN,   1},
      '{6, 0, 24, S_OF1REN,   1},
      '{6, 0, 25, S_OF1REN,   0},
      '{6, 0, 0,  S_IFSEL,    1},
      '{6, 0, 0,  S_IBWEN,    0},
      '{6, 0, 25, S_IBWEN,    1},
      '{4, 2, 0,  S_OF1WEN,   0},
      '{4, 2, 1,  S_OF1WEN,   1},
      '{4, 2, 1,  S_OF1WADDR, 32},
      '{4, 2, 16, S_OF1WADDR, 47},
      '{8, 0, 1,  S_OF2WEN,   1},
      '{8, 0, 1,  S_OF1WEN,   0},
      '{12, 3, 1, S_OF1WADDR, 3},
      '{12, 3, 1, S_OF12IN,   1},
      '{12, 3, 2, S_OF1WEN,   0},
      '{5, 0, 0,  S_BIAS,     6},
      '{9, 0, 0,  S_BIAS,     22},
      '{13, 0, 0, S_DONE,     1}
    };

    // Reset state, with start high to show it has no effect under reset.
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset state", sample(), '0);
    end
    start = 1'b0;
    rst = 1'b1;
    idle_gap(3);

    // Run aborted by reset inside C2_CP (tile 0, cnt 5).
    run_checked(0, L1_TILES * TILE_CYC + 2 * (LOAD_LEN + 1) + 5, 1'b0);
    #2 rst = 1'b0;
    #1 check("reset mid C2_CP", sample(), '0);
    repeat (2) begin
      @(negedge clk);
      check("held in reset", sample(), '0);
    end
    rst = 1'b1;
    idle_gap(2);

    // Full run after the abort: must restart at weight address 0.
    run_checked(0, TOTAL + 1, 1'b1);
    checks++;
    if (hits != NPROBE) begin
      errors++;
      $display("FAIL probe coverage: got %0d hits want %0d", hits, NPROBE);
    end

    // start held high through the run and pulsed in DONE: no restart.
    idle_gap(1 + $urandom_range(0, 4));
    run_checked(2, TOTAL + 2, 1'b0);

    // Random start noise during runs, random idle gaps between them.
    for (int r = 0; r < 2; r++) begin
      idle_gap(1 + $urandom_range(0, 7));
      run_checked(1, TOTAL + 1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller.md
# controller

Central sequencer of the CNN accelerator. After a one-cycle `start` pulse it runs three layers in fixed order: conv1, then conv2, then fully-connected (fc). It generates every BRAM read/write strobe and address, every buffer and PE write strobe, and every datapath mux select. It pulses `done` when the whole inference is finished.

## Interface
Parameters:
- CNT_W, 10, width of `cnt`
- IMG_AW / WGT_AW / BIAS_AW / OF1_AW / OF2_AW, 10 / 13 / 7 / 11 / 9, BRAM address widths
- IB_AW / WB_AW / PB_AW, 5 / 5 / 5, ifmap, weight and psum buffer address widths
- L1_TILES / L2_TILES / FC_TILES, 6 / 16 / 10, number of tiles per layer
- LOAD_LEN / COMP_LEN / WB_LEN, 25 / 24 / 16, words loaded, compute cycles and words written back per tile

Ports:
- clk in 1: clock, rising edge
- rst in 1: asynchronous, active-low reset
- start in 1: run request, sampled only in IDLE
- done out 1: one-cycle completion pulse
- cnt out CNT_W: in-state cycle counter
- bram_img_ren / bram_weight_ren / bram_bias_ren / bram_ofmap1_ren / bram_ofmap2_ren out 1, each with its matching address output (bram_ofmap1_raddr, bram_ofmap2_raddr for the ofmap BRAMs)
- bram_ofmap1_wen, bram_ofmap1_waddr, bram_ofmap2_wen, bram_ofmap2_waddr out: ofmap BRAM write port
- i_buff_wen / i_buff_w_addr / i_buff_clear, w_buff_wen / w_buff_w_addr / w_buff_clear out: buffer writes
- p_buff_wen out 1, p_buff_r_addr out PB_AW: psum buffer
- align_conv1 / align_conv2 out 1: layer alignment mode for the datapath
- fc_reg_wen / fc_reg_clear out 1: fc accumulator control
- ifmap_pe_wen / weight_pe_wen / MPSF_clear out 1: PE array control
- mux_if_sel / mux_pb_sel / mux_of_sel out 2; mux_of12_in_sel / mux_of12_out_sel out 1

## Operation
- State register `st` is 5 bits. Encoding: IDLE=0; C1_LW=1, C1_LI=2, C1_CP=3, C1_WB=4; C2_LW=5, C2_LI=6, C2_CP=7, C2_WB=8; FC_LW=9, FC_LI=10, FC_CP=11, FC_WB=12; DONE=13.
- `cnt` is cleared on every state change and increments by 1 each cycle within a state.
- State lengths: LW and LI states last LOAD_LEN+1 cycles; CP states last COMP_LEN cycles; WB states last WB_LEN+1 cycles.
- Per-tile sequence within a layer: LW→LI→CP→WB.
- From WB: go back to LW of the same layer while tile < TILES-1; otherwise go to the next layer's LW. FC_WB on the last fc tile goes to DONE.
- DONE lasts one cycle with done=1, then returns to IDLE.
- IDLE & start → C1_LW. start is ignored outside IDLE.
- LW states:
  - reads at cnt 0..LOAD_LEN-1: bram_weight_ren=1, bram_weight_addr = running weight pointer, +1 per read.
  - In cycle cnt=0: w_buff_clear=1, bram_bias_ren=1, bram_bias_addr = global tile index (0..L1+L2+FC_TILES-1).
  - Buffer write: w_buff_wen and w_buff_w_addr are the read enable and cnt registered by one cycle, so writes land at cnt 1..LOAD_LEN with addresses 0..LOAD_LEN-1.
- LI states: same pipelining as LW, into i_buff. i_buff_clear=1 at cnt=0.
  - Source by layer: conv1 reads bram_img (addr=cnt, mux_if_sel=0); conv2 reads ofmap1 (raddr=cnt, mux_if_sel=1); fc reads ofmap2 (raddr=cnt, mux_if_sel=2).
- CP states:
  - cnt=0: ifmap_pe_wen=1, weight_pe_wen=1, MPSF_clear=1.
  - cnt≥1: p_buff_wen=1.
  - align_conv1=1 throughout C1_CP; align_conv2=1 throughout C2_CP.
  - In FC_CP: fc_reg_wen=1 for all cycles, p_buff_wen=0. fc_reg_clear=1 during FC_LW cnt=0 of every fc tile.
- WB states:
  - p_buff_r_addr=cnt for cnt<WB_LEN.
  - Write strobe is the registered read-valid, so writes land at cnt 1..WB_LEN.
  - Destination: conv1 → ofmap1 (mux_of_sel=0, mux_of12_in_sel=0); conv2 → ofmap2 (mux_of_sel=1, mux_pb_sel=1); fc → ofmap1 (mux_of_sel=2, mux_pb_sel=2, mux_of12_in_sel=1).
  - FC_WB writes only one word (cnt=1).
  - Write addresses are per-layer running pointers starting at 0, +1 per write.
- mux_of12_out_sel=1 during all FC states, 0 otherwise.
- All strobes, addresses and selects not named for a state are 0 in that state.

## Timing
- Reset (rst=0, asynchronous): st=IDLE, cnt=0, all pointers and tile counters 0, every output 0.
- Reset asserted mid-run aborts the run immediately; done is not asserted.
- BRAM read latency is 1 cycle. All buffer and BRAM write strobes trail their reads by exactly 1 cycle.
- `start` high at edge k (in IDLE) → st=C1_LW after edge k; the first weight read is issued in that cycle.
- Total run length, start edge to the done cycle: sum over the three layers of TILES×(2(LOAD_LEN+1)+COMP_LEN+WB_LEN+1), +1 for DONE.
- Pointers wrap modulo 2^width.

## Test plan
- Reset low mid-C2_CP → st=0 and all outputs 0 immediately; after release, start re-runs from C1_LW with weight addr 0.
- Start pulse → st sequence 1,2,3,4 repeated 6×, then 5..8 16×, then 9..12 10×, then 13, then 0; done high exactly one cycle.
- C1_LW: weight addr 0..24 at cnt 0..24; w_buff_wen at cnt 1..25, w_buff_w_addr 0..24; second conv1 tile's weight addr starts at 25.
- C2_LI: bram_ofmap1_ren=1 and mux_if_sel=1 at cnt 0..24; i_buff_wen at cnt 1..25.
- C1_WB of tile 2: bram_ofmap1_waddr 32..47; C2_WB uses bram_ofmap2_wen only; FC_WB tile j writes ofmap1 address j with mux_of12_in_sel=1.
- start held high during a run, or pulsed in DONE → no restart and no extra done pulse.
